// File: rtl/pipe_pkg.sv
// Shared constants, stage-action encoding and index-width helper for the pipeline shell.
// Latency: none (declarations only).
// Backpressure: none.
package pipe_pkg;

  localparam int unsigned PIPE_STAGES = 5;
  localparam int unsigned PIPE_WIDTH  = 32;
  localparam int unsigned PIPE_CNT_W  = 32;

  // What a stage register does at the next edge.
  typedef enum logic [1:0] {
    ST_ADVANCE,
    ST_FREEZE,
    ST_BUBBLE,
    ST_KILL
  } stage_act_e;

  // Width of a stage index; never below 1 bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_shell_if.sv
// Bundle of the pipeline shell control, payload and observation signals.
// Latency: none (wiring only).
// Backpressure: in_ready is dropped by hold unless a flush is also requested.
interface pipe_shell_if
  import pipe_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES,
  parameter int WIDTH  = PIPE_WIDTH,
  parameter int CNT_W  = PIPE_CNT_W
) ();

  localparam int IW = idx_w(STAGES);
  localparam int OW = $clog2(STAGES + 1);

  logic                    in_valid;
  logic [WIDTH-1:0]        in_data;
  logic                    in_ready;
  logic                    hold;
  logic [IW-1:0]           hold_stage;
  logic                    flush;
  logic [IW-1:0]           flush_stage;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic [OW-1:0]           occupancy;
  logic [CNT_W-1:0]        retire_cnt;
  logic [CNT_W-1:0]        bubble_cnt;
  logic [CNT_W-1:0]        kill_cnt;

  // Pipeline side.
  modport slave (
    input  in_valid, in_data, hold, hold_stage, flush, flush_stage,
    output in_ready, out_valid, out_data, stage_valid, stage_data,
           occupancy, retire_cnt, bubble_cnt, kill_cnt
  );

  // Controller / source side.
  modport master (
    output in_valid, in_data, hold, hold_stage, flush, flush_stage,
    input  in_ready, out_valid, out_data, stage_valid, stage_data,
           occupancy, retire_cnt, bubble_cnt, kill_cnt
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus payload, updated according to an action code.
// Latency: 1 cycle from upstream inputs to registered outputs.
// Backpressure: none inside; freeze is expressed through act_i.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  stage_act_e       act_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  // Next state: load upstream, keep, or clear to an empty slot.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    case (act_i)
      ST_ADVANCE: begin
        vld_d = vld_i;
        dat_d = dat_i;
      end
      ST_FREEZE: begin
        vld_d = vld_q;
        dat_d = dat_q;
      end
      ST_BUBBLE, ST_KILL: begin
        vld_d = 1'b0;
        dat_d = '0;
      end
      default: begin
        vld_d = vld_q;
        dat_d = dat_q;
      end
    endcase
  end

  // Stage register; reset empties the slot immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/pipe_shell.sv
// In-order N-stage pipeline shell with freeze, bubble, younger-stage flush and event counters.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle when unimpeded.
// Backpressure: hold stalls the input (in_ready=0) unless flush discards the beat instead.
module pipe_shell
  import pipe_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES,
  parameter int WIDTH  = PIPE_WIDTH,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  pipe_shell_if.slave   bus
);

  localparam int IW = idx_w(STAGES);
  localparam int OW = $clog2(STAGES + 1);

  logic [IW-1:0]     hs_c;
  logic [IW-1:0]     fs_c;
  stage_act_e        act [STAGES];
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  dat [STAGES];
  logic              in_vld;
  logic [WIDTH-1:0]  in_dat;

  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CNT_W-1:0]  kill_q, kill_d;
  logic [CNT_W-1:0]  kill_inc;
  logic              retire_ev;
  logic              bubble_ev;
  logic [OW-1:0]     occ;
  logic [STAGES*WIDTH-1:0] data_flat;

  // Clamp out-of-range stage indices onto the oldest stage.
  always_comb begin
    hs_c = bus.hold_stage;
    fs_c = bus.flush_stage;
    if (int'(bus.hold_stage) >= STAGES) hs_c = IW'(STAGES - 1);
    if (int'(bus.flush_stage) >= STAGES) fs_c = IW'(STAGES - 1);
  end

  // Per-stage action: kill beats freeze, freeze beats bubble, else advance.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      act[i] = ST_ADVANCE;
      if (bus.flush && (i <= int'(fs_c))) begin
        act[i] = ST_KILL;
      end else if (bus.hold && (i <= int'(hs_c))) begin
        act[i] = ST_FREEZE;
      end else if (bus.hold && (i == int'(hs_c) + 1)) begin
        act[i] = ST_BUBBLE;
      end
    end
  end

  // Stage 0 sees a clean zero payload when nothing is offered.
  always_comb begin
    in_vld = bus.in_valid;
    in_dat = bus.in_valid ? bus.in_data : '0;
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
        pipe_stage_reg #(.WIDTH(WIDTH)) u_stage (
          .clk   (clk),
          .rst   (rst),
          .act_i (act[g]),
          .vld_i (in_vld),
          .dat_i (in_dat),
          .vld_o (vld[g]),
          .dat_o (dat[g])
        );
      end else begin : g_body
        pipe_stage_reg #(.WIDTH(WIDTH)) u_stage (
          .clk   (clk),
          .rst   (rst),
          .act_i (act[g]),
          .vld_i (vld[g-1]),
          .dat_i (dat[g-1]),
          .vld_o (vld[g]),
          .dat_o (dat[g])
        );
      end
    end
  endgenerate

  // Flatten stage payloads, stage i at [i*WIDTH +: WIDTH].
  always_comb begin
    data_flat = '0;
    for (int i = 0; i < STAGES; i++) begin
      data_flat[i*WIDTH +: WIDTH] = dat[i];
    end
  end

  // Event detection: the oldest entry retires when it leaves without being
  // frozen or killed; a bubble counts whenever one is requested below the top.
  always_comb begin
    retire_ev = vld[STAGES-1] &&
                ((act[STAGES-1] == ST_ADVANCE) || (act[STAGES-1] == ST_BUBBLE));
    bubble_ev = bus.hold && (int'(hs_c) < STAGES - 1);
    kill_inc  = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (vld[i] && (act[i] == ST_KILL)) kill_inc = kill_inc + CNT_W'(1);
    end
  end

  // Counter next state; all wrap naturally.
  always_comb begin
    retire_d = retire_q + (retire_ev ? CNT_W'(1) : CNT_W'(0));
    bubble_d = bubble_q + (bubble_ev ? CNT_W'(1) : CNT_W'(0));
    kill_d   = kill_q + kill_inc;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_q <= '0;
      bubble_q <= '0;
      kill_q   <= '0;
    end else begin
      retire_q <= retire_d;
      bubble_q <= bubble_d;
      kill_q   <= kill_d;
    end
  end

  // Occupancy is a plain popcount of the stage valid registers.
  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ = occ + OW'(vld[i]);
    end
  end

  assign bus.in_ready    = ~bus.hold | bus.flush;
  assign bus.out_valid   = vld[STAGES-1];
  assign bus.out_data    = dat[STAGES-1];
  assign bus.stage_valid = vld;
  assign bus.stage_data  = data_flat;
  assign bus.occupancy   = occ;
  assign bus.retire_cnt  = retire_q;
  assign bus.bubble_cnt  = bubble_q;
  assign bus.kill_cnt    = kill_q;

endmodule

// File: tb/tb_pipe_shell.sv
// Directed bench for pipe_shell: fill, stall, flush, flush+hold, freeze, counter wrap, async reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: source holds its beat while in_ready is low.
module tb_pipe_shell;
  import pipe_pkg::*;

  localparam int S = 5;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_shell_if #(.STAGES(S), .WIDTH(W), .CNT_W(32)) bus ();
  pipe_shell_if #(.STAGES(S), .WIDTH(W), .CNT_W(4))  bus4 ();

  pipe_shell #(.STAGES(S), .WIDTH(W), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_shell #(.STAGES(S), .WIDTH(W), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] seen [$];
  logic [31:0] expq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sdat(input int i);
    return bus.stage_data[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.out_valid === 1'b1) seen.push_back(bus.out_data);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic h,
                       input logic [2:0] hs, input logic f, input logic [2:0] fs);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.hold        = h;
    bus.hold_stage  = hs;
    bus.flush       = f;
    bus.flush_stage = fs;
  endtask

  task automatic idle4();
    bus4.in_valid    = 1'b0;
    bus4.in_data     = '0;
    bus4.hold        = 1'b0;
    bus4.hold_stage  = '0;
    bus4.flush       = 1'b0;
    bus4.flush_stage = '0;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    idle4();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    seen.delete();
  endtask

  task automatic fill(input logic [31:0] base);
    for (int k = 1; k <= S; k++) begin
      drive(1'b1, base + 32'(k), 1'b0, 3'd0, 1'b0, 3'd0);
      tick();
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 64'(seen.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < seen.size(); i++) begin
      chk(tag, 64'(seen[i]), 64'(expq[i]));
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    idle4();

    // Reset state while rst is held low.
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_stage_valid", 64'(bus.stage_valid), 64'd0);
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("rst_retire", 64'(bus.retire_cnt), 64'd0);
    chk("rst_bubble", 64'(bus.bubble_cnt), 64'd0);
    chk("rst_kill", 64'(bus.kill_cnt), 64'd0);
    chk("rst_in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.hold = 1'b1;
    #1;
    chk("rst_in_ready_hold", 64'(bus.in_ready), 64'd0);
    bus.hold = 1'b0;
    rst = 1'b1;

    // Fill and drain: 0x11..0x88, first retire 5 edges after the first accept.
    for (int k = 0; k < 13; k++) begin
      drive(k < 8, (k < 8) ? 32'h11 * 32'(k + 1) : 32'h0, 1'b0, 3'd0, 1'b0, 3'd0);
      tick();
      chk("fill_out_valid", 64'(bus.out_valid), (k >= 4 && k < 12) ? 64'd1 : 64'd0);
      chk("fill_out_data", 64'(bus.out_data),
          (k >= 4 && k < 12) ? 64'(32'h11 * 32'(k - 3)) : 64'd0);
    end
    chk("fill_retire", 64'(bus.retire_cnt), 64'd8);
    chk("fill_occupancy", 64'(bus.occupancy), 64'd0);

    // Mid-pipe stall: hold stages 0-1 for 3 cycles, bubbles appear at stage 2.
    do_reset();
    fill(32'hA0);
    drive(1'b1, 32'hA6, 1'b1, 3'd1, 1'b0, 3'd0);
    #1;
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("stall_s0", 64'(sdat(0)), 64'hA5);
      chk("stall_s1", 64'(sdat(1)), 64'hA4);
      chk("stall_v01", 64'(bus.stage_valid[1:0]), 64'd3);
      chk("stall_v2", 64'(bus.stage_valid[2]), 64'd0);
      chk("stall_s2", 64'(sdat(2)), 64'd0);
    end
    chk("stall_bubble", 64'(bus.bubble_cnt), 64'd3);
    drive(1'b1, 32'hA6, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    repeat (6) tick();
    expq = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6};
    check_log("stall_log");
    chk("stall_retire", 64'(bus.retire_cnt), 64'd6);
    chk("stall_bubble_after", 64'(bus.bubble_cnt), 64'd3);

    // Flush stages 0-2 with a full pipe; offered beat 0xB6 is discarded.
    do_reset();
    fill(32'hB0);
    drive(1'b1, 32'hB6, 1'b0, 3'd0, 1'b1, 3'd2);
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("flush_valid", 64'(bus.stage_valid), 64'b11000);
    for (int i = 0; i < 3; i++) chk("flush_zero", 64'(sdat(i)), 64'd0);
    chk("flush_s3", 64'(sdat(3)), 64'hB3);
    chk("flush_s4", 64'(sdat(4)), 64'hB2);
    chk("flush_kill", 64'(bus.kill_cnt), 64'd3);
    drive(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    repeat (5) tick();
    expq = '{32'hB1, 32'hB2, 32'hB3};
    check_log("flush_log");
    chk("flush_retire", 64'(bus.retire_cnt), 64'd3);

    // Flush stage 0 while holding stages 0-2.
    do_reset();
    fill(32'hC0);
    drive(1'b1, 32'hC6, 1'b1, 3'd2, 1'b1, 3'd0);
    #1;
    chk("fh_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("fh_valid", 64'(bus.stage_valid), 64'b10110);
    chk("fh_s0", 64'(sdat(0)), 64'd0);
    chk("fh_s1", 64'(sdat(1)), 64'hC4);
    chk("fh_s2", 64'(sdat(2)), 64'hC3);
    chk("fh_s3", 64'(sdat(3)), 64'd0);
    chk("fh_s4", 64'(sdat(4)), 64'hC2);
    chk("fh_kill", 64'(bus.kill_cnt), 64'd1);
    chk("fh_bubble", 64'(bus.bubble_cnt), 64'd1);

    // Full freeze, last cycle with an out-of-range index that clamps to the top.
    do_reset();
    fill(32'hD0);
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 32'hD6, 1'b1, (j == 2) ? 3'd7 : 3'd4, 1'b0, 3'd0);
      tick();
      chk("frz_out_valid", 64'(bus.out_valid), 64'd1);
      chk("frz_out_data", 64'(bus.out_data), 64'hD1);
      chk("frz_retire", 64'(bus.retire_cnt), 64'd0);
      chk("frz_occupancy", 64'(bus.occupancy), 64'd5);
    end
    chk("frz_bubble", 64'(bus.bubble_cnt), 64'd0);
    drive(1'b1, 32'hD6, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    repeat (6) tick();
    expq = '{32'hD1, 32'hD1, 32'hD1, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5, 32'hD6};
    check_log("frz_log");
    chk("frz_retire_end", 64'(bus.retire_cnt), 64'd6);

    // 4-bit retire counter wraps after 17 retirements.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 32'(k + 1);
      tick();
    end
    bus4.in_valid = 1'b0;
    bus4.in_data  = '0;
    repeat (6) tick();
    chk("wrap_retire", 64'(bus4.retire_cnt), 64'd1);
    chk("wrap_occupancy", 64'(bus4.occupancy), 64'd0);

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'hE0 + 32'(k), 1'b0, 3'd0, 1'b0, 3'd0);
      tick();
    end
    chk("ar_pre_retire", 64'(bus.retire_cnt), 64'd3);
    chk("ar_pre_occupancy", 64'(bus.occupancy), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.stage_valid), 64'd0);
    chk("ar_occupancy", 64'(bus.occupancy), 64'd0);
    chk("ar_out_data", 64'(bus.out_data), 64'd0);
    chk("ar_retire", 64'(bus.retire_cnt), 64'd0);
    chk("ar_bubble", 64'(bus.bubble_cnt), 64'd0);
    chk("ar_kill", 64'(bus.kill_cnt), 64'd0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
